// File: rtl/ts_serial_rx.sv
// ts_serial_rx: serial MPEG-TS receiver. It oversamples the demod serial
// interface in the clk domain, assembles bytes MSB-first, checks sync/length
// integrity, and keeps lock status plus status counters.
module ts_serial_rx #(
  parameter logic [7:0]  SYNC_BYTE = 8'h47,
  parameter int unsigned PKT_LEN   = 188,
  parameter bit          CLK_EDGE  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        ts_clock,
  input  logic        ts_start,
  input  logic        ts_valid,
  input  logic        ts_data,
  output logic [7:0]  data,
  output logic        dval,
  output logic        strt,
  output logic        pkt_end,
  output logic        pkt_abort,
  output logic        locked,
  output logic [15:0] sync_err_cnt,
  output logic [15:0] short_pkt_cnt,
  output logic [15:0] pkts_ok
);

  localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_e;

  state_e state_q, state_d;

  // Synchroniser chains: bit 0 = s1, bit 1 = s2, bit 2 = s3. The bit inputs
  // are consumed at s2, so their s3 stage would never be read; ts_clock needs
  // s3 for edge detection. Alignment between the four inputs is unchanged.
  logic [2:0] clk_sync_q;
  logic [1:0] start_sync_q, valid_sync_q, data_sync_q;

  logic [6:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  streak_q, streak_d;
  logic [7:0]  data_q, data_d;
  logic        dval_q, dval_d;
  logic        strt_q, strt_d;
  logic        pkt_end_q, pkt_end_d;
  logic        pkt_abort_q, pkt_abort_d;
  logic        locked_q, locked_d;
  logic [15:0] sync_err_cnt_q, sync_err_cnt_d;
  logic [15:0] short_pkt_cnt_q, short_pkt_cnt_d;
  logic [15:0] pkts_ok_q, pkts_ok_d;

  logic       clk_s2, clk_s3, start_s2, valid_s2, data_s2;
  logic       sample_ev, bit_ev;
  logic       restart, misalign, byte_done, sync_bad, last_byte;
  logic [7:0] byte_w;
  logic [1:0] streak_inc;

  assign clk_s2   = clk_sync_q[1];
  assign clk_s3   = clk_sync_q[2];
  assign start_s2 = start_sync_q[1];
  assign valid_s2 = valid_sync_q[1];
  assign data_s2  = data_sync_q[1];

  assign sample_ev = CLK_EDGE ? (clk_s2 & ~clk_s3) : (~clk_s2 & clk_s3);
  assign bit_ev    = sample_ev & valid_s2;

  assign restart    = start_s2 && ((bit_cnt_q != 3'd0) || (byte_cnt_q != 8'd0));
  assign misalign   = !start_s2 && (bit_cnt_q == 3'd0) && (byte_cnt_q == 8'd0);
  assign byte_done  = (bit_cnt_q == 3'd7);
  assign byte_w     = {shift_q, data_s2};
  assign sync_bad   = (byte_cnt_q == 8'd0) && (byte_w != SYNC_BYTE);
  assign last_byte  = (byte_cnt_q == LAST_BYTE);
  assign streak_inc = (streak_q == 2'd2) ? 2'd2 : streak_q + 2'd1;

  // Input synchronisers for the asynchronous demod interface
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= '0;
      start_sync_q <= '0;
      valid_sync_q <= '0;
      data_sync_q  <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[1:0], ts_clock};
      start_sync_q <= {start_sync_q[0], ts_start};
      valid_sync_q <= {valid_sync_q[0], ts_valid};
      data_sync_q  <= {data_sync_q[0], ts_data};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // Next-state: enter RECV on a start bit, fall back to HUNT on sync loss or disable
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = HUNT;
    end else if (bit_ev) begin
      case (state_q)
        HUNT: if (start_s2) state_d = RECV;
        RECV: begin
          if (restart)                     state_d = RECV;
          else if (misalign)               state_d = HUNT;
          else if (byte_done && sync_bad)  state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output/datapath decisions taken on each valid sample event
  always_comb begin
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    byte_cnt_d      = byte_cnt_q;
    streak_d        = streak_q;
    data_d          = data_q;
    dval_d          = 1'b0;
    strt_d          = 1'b0;
    pkt_end_d       = 1'b0;
    pkt_abort_d     = 1'b0;
    locked_d        = locked_q;
    sync_err_cnt_d  = sync_err_cnt_q;
    short_pkt_cnt_d = short_pkt_cnt_q;
    pkts_ok_d       = pkts_ok_q;

    if (!en) begin
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      streak_d    = '0;
      locked_d    = 1'b0;
      pkt_abort_d = (state_q == RECV) && (byte_cnt_q != 8'd0);
    end else if (bit_ev) begin
      case (state_q)
        HUNT: begin
          if (start_s2) begin
            shift_d    = {shift_q[5:0], data_s2};
            bit_cnt_d  = 3'd1;
            byte_cnt_d = '0;
          end
        end
        RECV: begin
          if (restart) begin
            // Truncated packet: this start bit becomes bit 7 of a fresh byte 0
            short_pkt_cnt_d = (short_pkt_cnt_q == '1) ? short_pkt_cnt_q
                                                      : short_pkt_cnt_q + 16'd1;
            pkt_abort_d = 1'b1;
            locked_d    = 1'b0;
            streak_d    = '0;
            shift_d     = {shift_q[5:0], data_s2};
            bit_cnt_d   = 3'd1;
            byte_cnt_d  = '0;
          end else if (misalign) begin
            sync_err_cnt_d = (sync_err_cnt_q == '1) ? sync_err_cnt_q
                                                    : sync_err_cnt_q + 16'd1;
            locked_d   = 1'b0;
            streak_d   = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end else begin
            shift_d = {shift_q[5:0], data_s2};
            if (!byte_done) begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end else begin
              bit_cnt_d = '0;
              if (sync_bad) begin
                sync_err_cnt_d = (sync_err_cnt_q == '1) ? sync_err_cnt_q
                                                        : sync_err_cnt_q + 16'd1;
                locked_d   = 1'b0;
                streak_d   = '0;
                byte_cnt_d = '0;
              end else begin
                data_d    = byte_w;
                dval_d    = 1'b1;
                strt_d    = (byte_cnt_q == 8'd0);
                pkt_end_d = last_byte;
                if (last_byte) begin
                  pkts_ok_d  = pkts_ok_q + 16'd1;
                  streak_d   = streak_inc;
                  locked_d   = (streak_inc == 2'd2);
                  byte_cnt_d = '0;
                end else begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      byte_cnt_q      <= '0;
      streak_q        <= '0;
      data_q          <= '0;
      dval_q          <= 1'b0;
      strt_q          <= 1'b0;
      pkt_end_q       <= 1'b0;
      pkt_abort_q     <= 1'b0;
      locked_q        <= 1'b0;
      sync_err_cnt_q  <= '0;
      short_pkt_cnt_q <= '0;
      pkts_ok_q       <= '0;
    end else begin
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_cnt_q      <= byte_cnt_d;
      streak_q        <= streak_d;
      data_q          <= data_d;
      dval_q          <= dval_d;
      strt_q          <= strt_d;
      pkt_end_q       <= pkt_end_d;
      pkt_abort_q     <= pkt_abort_d;
      locked_q        <= locked_d;
      sync_err_cnt_q  <= sync_err_cnt_d;
      short_pkt_cnt_q <= short_pkt_cnt_d;
      pkts_ok_q       <= pkts_ok_d;
    end
  end

  assign data          = data_q;
  assign dval          = dval_q;
  assign strt          = strt_q;
  assign pkt_end       = pkt_end_q;
  assign pkt_abort     = pkt_abort_q;
  assign locked        = locked_q;
  assign sync_err_cnt  = sync_err_cnt_q;
  assign short_pkt_cnt = short_pkt_cnt_q;
  assign pkts_ok       = pkts_ok_q;

endmodule

// File: tb/tb_ts_serial_rx.sv
// Bench for ts_serial_rx: directed packet table, hand-written corner cases,
// then randomized packets checked against a packet-level reference model.
module tb_ts_serial_rx;

  localparam int unsigned PLEN = 16;
  localparam int unsigned HALF = 3;
  localparam logic [7:0]  SYNC = 8'h47;

  logic        clk = 1'b0;
  logic        reset, en, ts_clock, ts_start, ts_valid, ts_data;
  logic [7:0]  data;
  logic        dval, strt, pkt_end, pkt_abort, locked;
  logic [15:0] sync_err_cnt, short_pkt_cnt, pkts_ok;

  always #5 clk = ~clk;

  ts_serial_rx #(.SYNC_BYTE(SYNC), .PKT_LEN(PLEN), .CLK_EDGE(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en),
    .ts_clock(ts_clock), .ts_start(ts_start), .ts_valid(ts_valid), .ts_data(ts_data),
    .data(data), .dval(dval), .strt(strt), .pkt_end(pkt_end), .pkt_abort(pkt_abort),
    .locked(locked), .sync_err_cnt(sync_err_cnt), .short_pkt_cnt(short_pkt_cnt),
    .pkts_ok(pkts_ok)
  );

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [7:0]  first;
    int          nbytes;
    int          nbits;
    int          gap;
    int          dv;
    logic [15:0] se, sh, ok;
    logic        lk;
    int          ab;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Observed: {strt, pkt_end, data} per dval pulse, and abort pulse count
  logic [9:0] got_q [$];
  logic [9:0] exp_q [$];
  int         got_aborts = 0;

  // Reference model state, one update per transmitted packet
  logic [15:0] m_se, m_sh, m_ok;
  int          m_streak, m_aborts;
  bit          m_open;

  always @(negedge clk) begin
    if (dval) got_q.push_back({strt, pkt_end, data});
    if (pkt_abort) got_aborts++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic void model_reset();
    m_se = '0; m_sh = '0; m_ok = '0;
    m_streak = 0; m_open = 1'b0;
  endfunction

  // Packet-level rules: a pending incomplete packet is aborted by the next
  // start; a bad first byte counts a sync error and delivers nothing; a good
  // packet delivers every complete byte and counts only if full length.
  function automatic void model_packet(input bq_t bytes, input int nbytes);
    if (m_open) begin
      m_sh = sat16(m_sh);
      m_aborts++;
      m_streak = 0;
      m_open = 1'b0;
    end
    if (bytes[0] != SYNC) begin
      m_se = sat16(m_se);
      m_streak = 0;
    end else begin
      for (int i = 0; i < nbytes; i++)
        exp_q.push_back({(i == 0), (i == int'(PLEN) - 1), bytes[i]});
      if (nbytes == int'(PLEN)) begin
        m_ok = m_ok + 16'd1;
        m_streak = (m_streak >= 2) ? 2 : m_streak + 1;
      end else begin
        m_open = 1'b1;
      end
    end
  endfunction

  task automatic send_bit(input logic st, input logic v, input logic d);
    ts_start = st; ts_valid = v; ts_data = d; ts_clock = 1'b0;
    repeat (HALF) @(negedge clk);
    ts_clock = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_gap();
    send_bit(1'($urandom), 1'b0, 1'($urandom));
  endtask

  // gap: 0 none, 1 five invalid edges inside byte 5, 2 random invalid edges
  task automatic run_packet(input logic [7:0] first, input int nbytes, input int nbits,
                            input int gap);
    bq_t bytes;
    int  total, pos;
    bytes = {};
    bytes.push_back(first);
    for (int i = 1; i < nbytes + ((nbits > 0) ? 1 : 0); i++) bytes.push_back(8'($urandom));
    model_packet(bytes, nbytes);
    total = nbytes * 8 + nbits;
    pos = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      for (int k = 7; k >= 0; k--) begin
        if (pos < total) begin
          if (gap == 1 && i == 5 && k == 4) repeat (5) send_gap();
          if (gap == 2 && $urandom_range(0, 9) == 0) send_gap();
          send_bit((i == 0 && k == 7), 1'b1, bytes[i][k]);
        end
        pos++;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all(input string tag, output int ndv);
    int n;
    ndv = got_q.size();
    check({tag, " dval count"}, ndv, exp_q.size());
    n = (ndv < exp_q.size()) ? ndv : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, " byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check({tag, " sync_err_cnt"}, sync_err_cnt, m_se);
    check({tag, " short_pkt_cnt"}, short_pkt_cnt, m_sh);
    check({tag, " pkts_ok"}, pkts_ok, m_ok);
    check({tag, " locked"}, locked, (m_streak >= 2));
    check({tag, " aborts"}, got_aborts, m_aborts);
  endtask

  initial begin
    vec_t tbl [11];
    int   ndv;
    logic [7:0] f;
    int   nb, nx;

    // {first, nbytes, extra bits, gap, dvals, sync_err, short, ok, locked, aborts}
    tbl[0]  = '{8'h47, 16, 0, 0, 16, 16'd0, 16'd0, 16'd1, 1'b0, 0};
    tbl[1]  = '{8'h47, 16, 0, 1, 16, 16'd0, 16'd0, 16'd2, 1'b1, 0};
    tbl[2]  = '{8'h47, 16, 0, 0, 16, 16'd0, 16'd0, 16'd3, 1'b1, 0};
    tbl[3]  = '{8'h46, 16, 0, 0,  0, 16'd1, 16'd0, 16'd3, 1'b0, 0};
    tbl[4]  = '{8'h47, 16, 0, 0, 16, 16'd1, 16'd0, 16'd4, 1'b0, 0};
    tbl[5]  = '{8'h47, 10, 3, 0, 10, 16'd1, 16'd0, 16'd4, 1'b0, 0};
    tbl[6]  = '{8'h47, 16, 0, 0, 16, 16'd1, 16'd1, 16'd5, 1'b0, 1};
    tbl[7]  = '{8'h47, 16, 0, 0, 16, 16'd1, 16'd1, 16'd6, 1'b1, 1};
    tbl[8]  = '{8'h47,  5, 0, 0,  5, 16'd1, 16'd1, 16'd6, 1'b1, 1};
    tbl[9]  = '{8'h46, 16, 0, 0,  0, 16'd2, 16'd2, 16'd6, 1'b0, 2};
    tbl[10] = '{8'h47, 16, 0, 0, 16, 16'd2, 16'd2, 16'd7, 1'b0, 2};

    reset = 1'b1; en = 1'b1;
    ts_clock = 1'b0; ts_start = 1'b0; ts_valid = 1'b0; ts_data = 1'b0;
    model_reset();
    m_aborts = 0;
    repeat (3) @(negedge clk);
    check("reset data", data, 8'h00);
    check("reset pulses", {dval, strt, pkt_end, pkt_abort}, 4'b0000);
    check("reset locked", locked, 1'b0);
    check("reset counters", {sync_err_cnt, short_pkt_cnt, pkts_ok}, 48'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed packet table
    for (int r = 0; r < 11; r++) begin
      run_packet(tbl[r].first, tbl[r].nbytes, tbl[r].nbits, tbl[r].gap);
      check_all("table", ndv);
      check("tbl dvals", ndv, tbl[r].dv);
      check("tbl sync_err_cnt", sync_err_cnt, tbl[r].se);
      check("tbl short_pkt_cnt", short_pkt_cnt, tbl[r].sh);
      check("tbl pkts_ok", pkts_ok, tbl[r].ok);
      check("tbl locked", locked, tbl[r].lk);
      check("tbl aborts", got_aborts, tbl[r].ab);
    end

    // Lost alignment: after a full packet the next bit 0 arrives without start
    run_packet(SYNC, int'(PLEN), 0, 0);
    check_all("pre-misalign", ndv);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 1'($urandom));
    repeat (4) @(negedge clk);
    m_se = sat16(m_se);
    m_streak = 0;
    check_all("misalign", ndv);
    run_packet(SYNC, int'(PLEN), 0, 0);
    check_all("post-misalign", ndv);

    // Reset in the middle of a packet: everything clears, no abort pulse
    run_packet(SYNC, 5, 3, 0);
    check_all("pre-reset", ndv);
    ts_clock = 1'b0; ts_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset data", data, 8'h00);
    check("midreset pulses", {dval, strt, pkt_end, pkt_abort, locked}, 5'b00000);
    check("midreset counters", {sync_err_cnt, short_pkt_cnt, pkts_ok}, 48'h0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("midreset no abort", got_aborts, m_aborts);
    run_packet(SYNC, int'(PLEN), 0, 0);
    check_all("after reset", ndv);

    // Enable dropped mid-packet: one abort, counters held, bits ignored
    run_packet(SYNC, 5, 0, 0);
    check_all("pre-disable", ndv);
    en = 1'b0;
    m_aborts++; m_open = 1'b0; m_streak = 0;
    send_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b1, 1'($urandom));
    repeat (4) @(negedge clk);
    check_all("disabled", ndv);
    en = 1'b1;
    repeat (2) @(negedge clk);
    run_packet(SYNC, int'(PLEN), 0, 2);
    check_all("re-enabled", ndv);

    // Saturation of sync_err_cnt and wrap of pkts_ok
    force dut.sync_err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.sync_err_cnt_q;
    m_se = 16'hFFFE;
    for (int i = 0; i < 3; i++) run_packet(8'h46, 2, 0, 0);
    check_all("saturate", ndv);
    check("sync_err saturated", sync_err_cnt, 16'hFFFF);
    force dut.pkts_ok_q = 16'hFFFF;
    @(negedge clk);
    release dut.pkts_ok_q;
    m_ok = 16'hFFFF;
    run_packet(SYNC, int'(PLEN), 0, 0);
    check_all("wrap", ndv);
    check("pkts_ok wrapped", pkts_ok, 16'h0000);

    // Randomized packets against the reference model
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 6) == 0) begin
        f = 8'($urandom);
        if (f == SYNC) f = f ^ 8'h01;
      end else begin
        f = SYNC;
      end
      if ($urandom_range(0, 9) < 7) begin
        nb = int'(PLEN);
        nx = 0;
      end else begin
        nb = $urandom_range(1, PLEN - 1);
        nx = $urandom_range(0, 7);
      end
      run_packet(f, nb, nx, 2);
      check_all("random", ndv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
